fp_mul_seq: RTL and testbench
=============================

Name: fp_mul_seq

Overview:
Parametrised, iterative floating-point multiplier. It is the sequential successor to the combinational sign/exponent/mantissa combine stage.
- Takes two packed operands {sign, exponent, fraction} and forms the sign and biased exponent.
- Multiplies the hidden-bit mantissas with a one-bit-per-cycle shift-add datapath, then normalises and packs the result.
- Sits behind the ALU operand registers, with a start/busy/done handshake to the ALU controller.

Parameters:
- EXP_W, 8, exponent field width in bits.
- FRAC_W, 23, fraction field width in bits (hidden bit not included).
- BIAS, 127, exponent bias. Must equal 2^(EXP_W-1)-1.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- op_a  input  1+EXP_W+FRAC_W  operand A, packed {sign, exponent, fraction}.
- op_b  input  1+EXP_W+FRAC_W  operand B, same packing.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  1+EXP_W+FRAC_W  packed product.
- overflow  output  1  exponent overflow for the held result.
- underflow  output  1  exponent underflow for the held result.

Behaviour:
- Reset: rst=1 at a clock edge forces state=IDLE. busy, done, result, overflow and underflow all become 0. Reset mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE: start=1 latches op_a/op_b and goes to MULT.
  - MULT: runs exactly FRAC_W+1 cycles, consuming one multiplier bit per cycle (LSB first) into a 2*(FRAC_W+1)-bit accumulator, then goes to NORM.
  - NORM: 1 cycle; normalises and packs, then goes to DONE.
  - DONE: done=1 for 1 cycle, then back to IDLE.
- Latency: done is high exactly FRAC_W+3 edges after the edge that sampled start (26 cycles at default). Latency is constant for all operands, including zero.
- start in any state other than IDLE is ignored. start held high re-triggers on the cycle after DONE.
- Sign: sign_a XOR sign_b.
- Exponent:
  - Computed in EXP_W+2-bit signed arithmetic: e = ea + eb - BIAS.
  - If the product MSB (bit 2*FRAC_W+1) is 1, shift the product right 1 and set e = e+1.
  - The fraction is the FRAC_W bits below the leading 1. Rounding is truncation.
- Zero: either operand with exponent field 0 is treated as zero (denormals flush to zero). Result = {sign, 0, 0}, with no flags raised.
- Overflow: e >= 2^EXP_W-1 produces result {sign, all-ones, 0} and overflow=1.
- Underflow: e <= 0 produces result {sign, 0, 0} and underflow=1.
- result, overflow and underflow update only on the NORM-to-DONE edge. They hold until the next completed operation and do not change while busy.

Optional Feature:
FP_MUL_SPECIAL_EN.
- Defined: an exponent field of all ones on an input is treated as Inf (fraction 0) or NaN (fraction nonzero).
  - NaN on either input gives result {0, all-ones, 1 followed by FRAC_W-1 zeros}.
  - Inf x zero gives that same NaN.
  - Inf x finite-nonzero gives {sign, all-ones, 0}.
  - overflow and underflow are 0 in all these cases. Latency is unchanged.
- Undefined: an all-ones exponent on an input is processed as an ordinary normal number through the overflow/underflow rules above.

Test Plan:
1. 0x3FC00000 x 0x40000000 (1.5 x 2.0) -> result 0x40400000, flags 0, done exactly 26 cycles after start.
2. 0xC0000000 x 0x40400000 (-2 x 3) -> 0xC0C00000. Then 0x3FC00000 x 0x3FC00000 (1.5 x 1.5, normalisation path) -> 0x40100000.
3. 0x00000000 x 0x40490FDB -> 0x00000000, flags 0. Then 0x7F000000 x 0x7F000000 -> 0x7F800000 with overflow=1.
4. 0x00800000 x 0x00800000 -> 0x00000000 with underflow=1. Then 0x80800000 x 0x00800000 -> 0x80000000 with underflow=1.
5. Handshake: pulse start again at cycles 5 and 20 of an operation -> ignored, a single done, result unchanged. Assert rst at cycle 10 of a new operation -> all outputs 0, no done, IDLE on the next cycle.
6. EXP_W=5, FRAC_W=10, BIAS=15: 0x3E00 x 0x4000 -> 0x4200, done 13 cycles after start. With FP_MUL_SPECIAL_EN: 0x7F800000 x 0x00000000 -> 0x7FC00000.

Source files
------------

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: iterative shift-add floating-point multiplier.
// Define FP_MUL_SPECIAL_EN to decode all-ones exponents as Inf/NaN.
// If it is left undefined, all-ones exponents are treated as ordinary normals.
module fp_mul_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [EXP_W+FRAC_W:0] op_a,
    input  logic [EXP_W+FRAC_W:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [EXP_W+FRAC_W:0] result,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int W  = EXP_W + FRAC_W + 1;
    localparam int M  = FRAC_W + 1;
    localparam int EP = EXP_W + 2;
    localparam int CW = $clog2(M + 1);
    localparam logic [EP-1:0] E_MAX  = EP'((1 << EXP_W) - 1);
    localparam logic [EP-1:0] E_BIAS = EP'(BIAS);

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   a_q, b_q, result_q, result_d;
    logic [2*M-1:0] prod_q, prod_d;
    logic [M:0]     sum;
    logic           busy_q, done_q, ovf_q, unf_q, ovf_d, unf_d;
    logic [EXP_W-1:0]  ea, eb;
    logic [EP-1:0]     e_raw, e_n;
    logic [FRAC_W-1:0] frac;
    logic              sgn, zero, nan_c, inf_c;

    assign ea    = a_q[W-2:FRAC_W];
    assign eb    = b_q[W-2:FRAC_W];
    assign sgn   = a_q[W-1] ^ b_q[W-1];
    assign zero  = (ea == '0) || (eb == '0);
    assign e_raw = {2'b00, ea} + {2'b00, eb} - E_BIAS;
    assign e_n   = e_raw + {{(EP-1){1'b0}}, prod_q[2*M-1]};
    assign frac  = prod_q[2*M-1] ? prod_q[2*M-2 -: FRAC_W] : prod_q[2*M-3 -: FRAC_W];

`ifdef FP_MUL_SPECIAL_EN
    logic a_inf, b_inf, a_nan, b_nan;
    assign a_inf = (&ea) && (a_q[FRAC_W-1:0] == '0);
    assign b_inf = (&eb) && (b_q[FRAC_W-1:0] == '0);
    assign a_nan = (&ea) && (a_q[FRAC_W-1:0] != '0);
    assign b_nan = (&eb) && (b_q[FRAC_W-1:0] != '0);
    assign nan_c = a_nan || b_nan || (a_inf && eb == '0) || (b_inf && ea == '0);
    assign inf_c = a_inf || b_inf;
`else
    assign nan_c = 1'b0;
    assign inf_c = 1'b0;
`endif

    // One shift-add step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    always_comb begin
        sum    = {1'b0, prod_q[2*M-1:M]} + (prod_q[0] ? {1'b0, 1'b1, a_q[FRAC_W-1:0]} : '0);
        prod_d = {sum, prod_q[M-1:1]};
    end

    // Normalise, classify and pack the finished product; specials take priority over zero and range checks.
    always_comb begin
        ovf_d    = !nan_c && !inf_c && !zero && !e_n[EP-1] && (e_n >= E_MAX);
        unf_d    = !nan_c && !inf_c && !zero && (e_n[EP-1] || e_n == '0);
        result_d = nan_c           ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}} :
                   (inf_c || ovf_d) ? {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
                   (zero || unf_d)  ? {sgn, {(W-1){1'b0}}} :
                                      {sgn, e_n[EXP_W-1:0], frac};
    end

    // Control FSM with registered handshake outputs and result hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        prod_q  <= {{M{1'b0}}, 1'b1, op_b[FRAC_W-1:0]};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MULT;
                    end
                end
                MULT: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(FRAC_W)) state_q <= NORM;
                end
                NORM: begin
                    result_q <= result_d;
                    ovf_q    <= ovf_d;
                    unf_q    <= unf_d;
                    state_q  <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vector bench for fp_mul_seq in single and half-precision configurations.
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst, start, start2;
    logic [31:0] op_a, op_b, result;
    logic [15:0] a2, b2, r2;
    logic        busy, done, overflow, underflow;
    logic        busy2, done2, ovf2, unf2;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    fp_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .overflow(overflow), .underflow(underflow)
    );

    fp_mul_seq #(.EXP_W(5), .FRAC_W(10), .BIAS(15)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op_a(a2), .op_b(b2),
        .busy(busy2), .done(done2), .result(r2), .overflow(ovf2), .underflow(unf2)
    );

    typedef struct {
        logic [31:0] a, b, r;
        logic        ov, un;
    } vec_t;

    vec_t v[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input bit hold, output int lat);
        @(negedge clk);
        op_a = a;
        op_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
    endtask

    initial begin
        int lat, cyc, dones;
        logic [31:0] held;
        v[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
        v[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0};
        v[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
        v[3]  = '{32'h00000000, 32'h40490FDB, 32'h00000000, 1'b0, 1'b0};
        v[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0};
        v[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
        v[6]  = '{32'h80800000, 32'h00800000, 32'h80000000, 1'b0, 1'b1};
        v[7]  = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0};
        v[8]  = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0};
        v[9]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1};
        v[10] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0};
        v[11] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0};
`ifdef FP_MUL_SPECIAL_EN
        v[12] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0};
        v[13] = '{32'h7F800000, 32'hBF800000, 32'hFF800000, 1'b0, 1'b0};
        v[14] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
`else
        v[12] = '{32'h7F800000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
        v[13] = '{32'h7F800000, 32'hBF800000, 32'hFF800000, 1'b1, 1'b0};
        v[14] = '{32'h7F800001, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0};
`endif
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        op_a = '0;
        op_b = '0;
        a2 = '0;
        b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset overflow", overflow, 0);
        check("reset underflow", underflow, 0);

        for (int i = 0; i < 15; i++) begin
            run(v[i].a, v[i].b, 1'b0, lat);
            check($sformatf("vec%0d latency", i), lat, 26);
            check($sformatf("vec%0d result", i), result, v[i].r);
            check($sformatf("vec%0d overflow", i), overflow, v[i].ov);
            check($sformatf("vec%0d underflow", i), underflow, v[i].un);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse width", i), done, 0);
            check($sformatf("vec%0d result hold", i), result, v[i].r);
        end

        @(negedge clk);
        op_a = 32'h7F000000;
        op_b = 32'h7F000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        held = '0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                held = result;
            end
            if (cyc == 5) check("busy mid op", busy, 1);
            start = (cyc == 5 || cyc == 20);
            op_a = 32'h3F800000;
            op_b = 32'h3F800000;
        end
        start = 1'b0;
        check("ignored start done count", dones, 1);
        check("ignored start result", held, 32'h7F800000);
        check("ignored start overflow", overflow, 1);

        @(negedge clk);
        op_a = 32'h3FC00000;
        op_b = 32'h3FC00000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        check("abort overflow", overflow, 0);
        check("abort underflow", underflow, 0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort no done", dones, 0);
        run(32'hC0000000, 32'h40400000, 1'b0, lat);
        check("after abort latency", lat, 26);
        check("after abort result", result, 32'hC0C00000);

        run(32'h3FC00000, 32'h40000000, 1'b1, lat);
        check("retrigger first latency", lat, 26);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (lat < 60 && !done) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("retrigger gap", lat, 27);
        check("retrigger result", result, 32'h40400000);

        @(negedge clk);
        a2 = 16'h3E00;
        b2 = 16'h4000;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (done2) break;
        end
        check("half latency", lat, 13);
        check("half result", 32'(r2), 32'h4200);
        check("half flags", {ovf2, unf2}, 0);

        @(negedge clk);
        a2 = 16'h7800;
        b2 = 16'h7800;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (done2) break;
        end
        check("half ovf latency", lat, 13);
        check("half ovf result", 32'(r2), 32'h7C00);
        check("half ovf flag", ovf2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
